// File: rtl/lshifter_seq_pkg.sv
// Shared definitions for the sequential left shifter.
//   - Default data and shift-amount widths.
//   - FSM state encoding (also driven out on the debug state port).
//   - Mode encoding for the latched rot input.
package lshifter_seq_pkg;

  localparam int LS_WIDTH = 8;
  localparam int LS_SHW   = 3;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam logic MODE_SHL = 1'b0;
  localparam logic MODE_ROL = 1'b1;

endpackage

// File: rtl/lshifter_seq_step.sv
// Combinational single-position left shift / rotate.
//   d       : input word
//   rot     : 1 = rotate (MSB re-enters at bit 0), 0 = zero fill
//   q       : d shifted left by one position
//   bit_out : the bit that leaves the top of the word (d[WIDTH-1])
module lshift_step
  import lshifter_seq_pkg::*;
#(
  parameter int WIDTH = LS_WIDTH
) (
  input  logic [WIDTH-1:0] d,
  input  logic             rot,
  output logic [WIDTH-1:0] q,
  output logic             bit_out
);

  logic w_fill;

  assign w_fill  = rot ? d[WIDTH-1] : 1'b0;
  assign q       = {d[WIDTH-2:0], w_fill};
  assign bit_out = d[WIDTH-1];

endmodule

// File: rtl/lshifter_seq.sv
// Multi-cycle left shift / rotate unit, one bit position per clock.
//   clk, rst  : clock and synchronous active-high reset
//   start     : request, sampled only while idle
//   a, s, rot : operand, shift amount, mode (1 = rotate); latched on accept
//   busy      : high whenever the FSM is not idle
//   done      : one-cycle completion pulse; out/cout valid in that cycle
//   out, cout : result and last bit shifted out of the MSB (0 when s = 0)
//   dbg_state : current FSM state, for observation only
//
// Handshake: start is accepted on a rising edge where the unit is idle and
// start is high. Further start pulses while busy are dropped, not queued.
// done rises exactly s+1 cycles after the accepting edge's cycle and lasts
// one cycle; out/cout are only ever written on entry to DONE.
module lshifter_seq
  import lshifter_seq_pkg::*;
#(
  parameter int WIDTH = LS_WIDTH,
  parameter int SHW   = LS_SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   s,
  input  logic             rot,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_wreg;
  logic [SHW-1:0]   r_cnt;
  logic             r_mode;
  logic [WIDTH-1:0] r_out;
  logic             r_cout;

  logic [WIDTH-1:0] w_shifted;
  logic             w_bit_out;

  lshift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .d       (r_wreg),
    .rot     (r_mode == MODE_ROL),
    .q       (w_shifted),
    .bit_out (w_bit_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_wreg  <= '0;
      r_cnt   <= '0;
      r_mode  <= MODE_SHL;
      r_out   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (s != '0) begin
              r_wreg  <= a;
              r_cnt   <= s;
              r_mode  <= rot;
              r_state <= ST_SHIFT;
            end else begin
              // Zero shift bypasses SHIFT entirely: result is the operand.
              r_out   <= a;
              r_cout  <= 1'b0;
              r_state <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          r_wreg <= w_shifted;
          r_cnt  <= r_cnt - CNT_ONE;
          // Last step: publish the shifted word and the bit that just left.
          if (r_cnt == CNT_ONE) begin
            r_out   <= w_shifted;
            r_cout  <= w_bit_out;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign out       = r_out;
  assign cout      = r_cout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_lshifter_seq.sv
// Directed testbench for lshifter_seq: a driver issues operations and
// pushes hand-computed results into a queue; a negedge monitor pops and
// checks them whenever done is seen, including the completion cycle.
module tb_lshifter_seq;
  import lshifter_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [2:0] s;
  logic       rot;
  logic       busy;
  logic       done;
  logic [7:0] out;
  logic       cout;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [8:0] exp_q[$];
  int         exp_cyc_q[$];

  lshifter_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .s         (s),
    .rot       (rot),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .cout      (cout),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) tick();
    check("idle_timeout", busy, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || busy); i++) tick();
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Issues one request; returns in cycle 1 (the cycle after acceptance).
  task automatic issue(input logic [7:0] ia, input logic [2:0] is, input logic ir,
                       input logic [7:0] eo, input logic ec, input bit push);
    wait_idle();
    a = ia; s = is; rot = ir; start = 1'b1;
    if (push) begin
      exp_q.push_back({eo, ec});
      exp_cyc_q.push_back(cyc + 1 + int'(is));
    end
    tick();
    start = 1'b0;
  endtask

  // Arithmetic reference for the sweep, written from the shift definitions.
  function automatic logic [8:0] model(input logic [7:0] ma, input int ms, input logic mr);
    logic [7:0] r;
    logic       c;
    r = ma << ms;
    if (mr && ms != 0) r = r | (ma >> (8 - ms));
    c = (ms == 0) ? 1'b0 : ma[8 - ms];
    return {r, c};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [7:0] last_out  = '0;
  logic       last_cout = 1'b0;
  logic       prev_done = 1'b0;

  always @(negedge clk) begin
    logic [8:0] e;
    int         ec;
    if (rst) begin
      last_out  = '0;
      last_cout = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        check("done_width", prev_done, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("out", out, e[8:1]);
          check("cout", cout, e[0]);
          check("done_cycle", cyc, ec);
        end
        last_out  = out;
        last_cout = cout;
      end else begin
        check("out_stable", {out, cout}, {last_out, last_cout});
      end
      prev_done = done;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int         acc_prev;
    logic [8:0] m;

    rst = 1'b1; start = 1'b0; a = '0; s = '0; rot = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out", out, 8'h00);
    check("rst_cout", cout, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // Logical s=3, with busy checked through cycles 1..4.
    issue(8'b00101011, 3'd3, 1'b0, 8'b01011000, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      check("busy_during_op", busy, 1);
      tick();
    end
    check("busy_after_op", busy, 0);

    issue(8'b00101011, 3'd3, 1'b1, 8'b01011001, 1'b1, 1'b1);
    issue(8'b00101011, 3'd7, 1'b0, 8'b10000000, 1'b1, 1'b1);
    issue(8'b00101011, 3'd7, 1'b1, 8'b10010101, 1'b1, 1'b1);
    drain();

    // s = 0: straight to DONE, never through SHIFT.
    issue(8'hA5, 3'd0, 1'b0, 8'hA5, 1'b0, 1'b1);
    check("s0_state_c1", dbg_state, ST_DONE);
    tick();
    check("s0_state_c2", dbg_state, ST_IDLE);
    drain();

    // Sweep both modes over every shift amount.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) begin
        m = model(8'hB4, k, r[0]);
        issue(8'hB4, 3'(k), r[0], m[8:1], m[0], 1'b1);
      end
    end
    drain();

    // start pulsed mid-operation with different operands is ignored.
    issue(8'b00101011, 3'd5, 1'b0, 8'h60, 1'b1, 1'b1);
    tick();
    a = 8'hFF; s = 3'd3; rot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; a = 8'h00;
    drain();

    // start held high: acceptances every s+2 cycles.
    wait_idle();
    a = 8'h81; s = 3'd2; rot = 1'b1; start = 1'b1;
    acc_prev = 0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 40 && busy; i++) tick();
      check("held_idle_timeout", busy, 0);
      exp_q.push_back({8'h06, 1'b0});
      exp_cyc_q.push_back(cyc + 1 + 2);
      if (k > 0) check("held_spacing", cyc - acc_prev, 4);
      acc_prev = cyc;
      tick();
    end
    start = 1'b0;
    drain();

    // Reset in cycle 3 of an s=6 operation aborts it without done.
    issue(8'b00101011, 3'd6, 1'b0, 8'h00, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_out", out, 8'h00);
    check("abort_cout", cout, 0);
    check("abort_busy", busy, 0);
    for (int i = 0; i < 10; i++) tick();
    check("abort_no_done_pending", exp_q.size(), 0);

    issue(8'hC3, 3'd1, 1'b0, 8'h86, 1'b1, 1'b1);
    drain();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
